// File: rtl/uart_bus_slave.sv
// Memory-mapped UART target: TX FIFO feeding a serializer, RX deserializer with a one-deep holding register.
// Define UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit in both directions.
module uart_bus_slave #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] bus_wdata_i,
    input  logic [31:0] bus_addr_i,
    input  logic        bus_we_i,
    input  logic [1:0]  bus_hb_i,
    input  logic        bus_ce_i,
    input  logic        bus_req_i,
    output logic [31:0] bus_rdata_o,
    output logic        uart_tx_o,
    input  logic        uart_rx_i,
    output logic        irq_o
);

    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } uartState_t;

    // Bus decode
    logic       w_acc, w_wr, w_rd, w_sizeOk;
    logic [1:0] w_off;
    logic       w_pushReq, w_ctrlWr, w_rxPop;
    logic       w_unused;

    assign w_acc     = bus_ce_i & bus_req_i;
    assign w_wr      = w_acc & bus_we_i;
    assign w_rd      = w_acc & ~bus_we_i;
    assign w_off     = bus_addr_i[3:2];
    assign w_sizeOk  = (bus_hb_i != 2'b11);
    assign w_pushReq = w_wr & w_sizeOk & (w_off == 2'd0);
    assign w_ctrlWr  = w_wr & w_sizeOk & (w_off == 2'd3);
    assign w_rxPop   = w_rd & (w_off == 2'd2);
    assign w_unused  = &{1'b0, bus_addr_i[31:4], bus_addr_i[1:0], bus_wdata_i[31:8]};

    // TX FIFO
    logic [7:0]  r_fifoMem [TX_FIFO_DEPTH];
    logic [AW:0] r_wrPtr, r_rdPtr;
    logic        w_txFull, w_txEmpty, w_txPop, w_push;

    assign w_txEmpty = (r_wrPtr == r_rdPtr);
    assign w_txFull  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign w_push    = w_pushReq & (~w_txFull | w_txPop);

    always_ff @(posedge clk_i) begin
        if (w_push)
            r_fifoMem[r_wrPtr[AW-1:0]] <= bus_wdata_i[7:0];
    end

    // TX serializer
    uartState_t r_txState, w_txStateNext;
    logic [CW-1:0] r_txCnt, w_txCntNext;
    logic [2:0]    r_txBitIdx, w_txBitNext;
    logic [7:0]    r_txShift, w_txShiftNext;
    logic          r_txOut, w_txOutNext;
    logic          w_txBitDone, w_txBusy;
`ifdef UART_PARITY_EN
    logic          r_txPar, w_txParNext;
`endif

    assign w_txBitDone = (r_txCnt == BIT_LAST);
    assign w_txBusy    = (r_txState != S_IDLE);

    always_comb begin
        w_txStateNext = r_txState;
        w_txCntNext   = w_txBitDone ? '0 : r_txCnt + 1'b1;
        w_txBitNext   = r_txBitIdx;
        w_txShiftNext = r_txShift;
        w_txPop       = 1'b0;
        w_txOutNext   = 1'b1;
`ifdef UART_PARITY_EN
        w_txParNext   = r_txPar;
`endif
        case (r_txState)
            S_IDLE: begin
                w_txCntNext = '0;
                if (!w_txEmpty) begin
                    w_txPop       = 1'b1;
                    w_txShiftNext = r_fifoMem[r_rdPtr[AW-1:0]];
`ifdef UART_PARITY_EN
                    w_txParNext   = ^r_fifoMem[r_rdPtr[AW-1:0]];
`endif
                    w_txStateNext = S_START;
                end
            end
            S_START: begin
                if (w_txBitDone) begin
                    w_txStateNext = S_DATA;
                    w_txBitNext   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_txBitDone) begin
                    w_txShiftNext = {1'b0, r_txShift[7:1]};
                    w_txBitNext   = r_txBitIdx + 3'd1;
                    if (r_txBitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_txStateNext = S_PARITY;
`else
                        w_txStateNext = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_txBitDone)
                    w_txStateNext = S_STOP;
            end
`endif
            S_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (w_txBitDone) begin
                    if (!w_txEmpty) begin
                        w_txPop       = 1'b1;
                        w_txShiftNext = r_fifoMem[r_rdPtr[AW-1:0]];
`ifdef UART_PARITY_EN
                        w_txParNext   = ^r_fifoMem[r_rdPtr[AW-1:0]];
`endif
                        w_txStateNext = S_START;
                    end else begin
                        w_txStateNext = S_IDLE;
                    end
                end
            end
            default: w_txStateNext = S_IDLE;
        endcase

        case (w_txStateNext)
            S_START:  w_txOutNext = 1'b0;
            S_DATA:   w_txOutNext = w_txShiftNext[0];
`ifdef UART_PARITY_EN
            S_PARITY: w_txOutNext = w_txParNext;
`endif
            default:  w_txOutNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_txState  <= S_IDLE;
            r_txCnt    <= '0;
            r_txBitIdx <= 3'd0;
            r_txShift  <= 8'h00;
            r_txOut    <= 1'b1;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
`ifdef UART_PARITY_EN
            r_txPar    <= 1'b0;
`endif
        end else begin
            r_txState  <= w_txStateNext;
            r_txCnt    <= w_txCntNext;
            r_txBitIdx <= w_txBitNext;
            r_txShift  <= w_txShiftNext;
            r_txOut    <= w_txOutNext;
`ifdef UART_PARITY_EN
            r_txPar    <= w_txParNext;
`endif
            if (w_push)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_txPop)
                r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    assign uart_tx_o = r_txOut;

    // RX deserializer
    logic          r_rxSync1, r_rxSync2, r_rxPrev;
    uartState_t    r_rxState, w_rxStateNext;
    logic [CW-1:0] r_rxCnt, w_rxCntNext;
    logic [2:0]    r_rxBitIdx, w_rxBitNext;
    logic [7:0]    r_rxShift, w_rxShiftNext;
    logic          w_rxDone;
`ifdef UART_PARITY_EN
    logic          r_rxParBit;
`endif

    always_comb begin
        w_rxStateNext = r_rxState;
        w_rxCntNext   = r_rxCnt + 1'b1;
        w_rxBitNext   = r_rxBitIdx;
        w_rxShiftNext = r_rxShift;
        w_rxDone      = 1'b0;
        case (r_rxState)
            S_IDLE: begin
                w_rxCntNext = '0;
                if (r_rxPrev & ~r_rxSync2)
                    w_rxStateNext = S_START;
            end
            S_START: begin
                if (r_rxCnt == BIT_HALF) begin
                    w_rxCntNext   = '0;
                    w_rxBitNext   = 3'd0;
                    w_rxStateNext = r_rxSync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rxCnt == BIT_LAST) begin
                    w_rxCntNext   = '0;
                    w_rxShiftNext = {r_rxSync2, r_rxShift[7:1]};
                    w_rxBitNext   = r_rxBitIdx + 3'd1;
                    if (r_rxBitIdx == 3'd7) begin
`ifdef UART_PARITY_EN
                        w_rxStateNext = S_PARITY;
`else
                        w_rxStateNext = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (r_rxCnt == BIT_LAST) begin
                    w_rxCntNext   = '0;
                    w_rxStateNext = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_rxCnt == BIT_LAST) begin
                    w_rxCntNext   = '0;
                    w_rxStateNext = S_IDLE;
                    w_rxDone      = r_rxSync2;
                end
            end
            default: w_rxStateNext = S_IDLE;
        endcase
    end

    // Holding register, status flags, control and interrupt
    logic [7:0] r_rxByte;
    logic       r_rxValid, r_rxOverrun, r_parityErr;
    logic [1:0] r_ctrl;
    logic       r_irq;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rxSync1   <= 1'b1;
            r_rxSync2   <= 1'b1;
            r_rxPrev    <= 1'b1;
            r_rxState   <= S_IDLE;
            r_rxCnt     <= '0;
            r_rxBitIdx  <= 3'd0;
            r_rxShift   <= 8'h00;
            r_rxByte    <= 8'h00;
            r_rxValid   <= 1'b0;
            r_rxOverrun <= 1'b0;
            r_parityErr <= 1'b0;
            r_ctrl      <= 2'b00;
            r_irq       <= 1'b0;
`ifdef UART_PARITY_EN
            r_rxParBit  <= 1'b0;
`endif
        end else begin
            r_rxSync1  <= uart_rx_i;
            r_rxSync2  <= r_rxSync1;
            r_rxPrev   <= r_rxSync2;
            r_rxState  <= w_rxStateNext;
            r_rxCnt    <= w_rxCntNext;
            r_rxBitIdx <= w_rxBitNext;
            r_rxShift  <= w_rxShiftNext;
`ifdef UART_PARITY_EN
            if (r_rxState == S_PARITY && r_rxCnt == BIT_LAST)
                r_rxParBit <= r_rxSync2;
`endif
            if (w_ctrlWr) begin
                r_ctrl <= bus_wdata_i[1:0];
                if (bus_wdata_i[2]) begin
                    r_rxOverrun <= 1'b0;
                    r_parityErr <= 1'b0;
                end
            end
            // A byte completing alongside a pop wins: valid stays set and no overrun.
            if (w_rxDone) begin
                r_rxByte  <= r_rxShift;
                r_rxValid <= 1'b1;
                if (r_rxValid & ~w_rxPop)
                    r_rxOverrun <= 1'b1;
`ifdef UART_PARITY_EN
                if (^r_rxShift ^ r_rxParBit)
                    r_parityErr <= 1'b1;
`endif
            end else if (w_rxPop) begin
                r_rxValid <= 1'b0;
            end
            r_irq <= (r_ctrl[0] & r_rxValid) | (r_ctrl[1] & w_txEmpty & ~w_txBusy);
        end
    end

    assign irq_o = r_irq;

    always_comb begin
        bus_rdata_o = 32'h0;
        if (w_rd) begin
            case (w_off)
                2'd1:    bus_rdata_o = {26'h0, r_parityErr, w_txBusy, r_rxOverrun,
                                        r_rxValid, w_txEmpty, w_txFull};
                2'd2:    bus_rdata_o = {24'h0, r_rxByte};
                2'd3:    bus_rdata_o = {30'h0, r_ctrl};
                default: bus_rdata_o = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed testbench for uart_bus_slave with CLKS_PER_BIT=8 and a 16-entry TX FIFO.
module tb_uart_bus_slave;

   localparam int CPB = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] busWdata = '0;
   logic [31:0] busAddr = '0;
   logic        busWe = 1'b0;
   logic [1:0]  busHb = 2'b00;
   logic        busCe = 1'b0;
   logic        busReq = 1'b0;
   logic [31:0] busRdata;
   logic        uartTx;
   logic        uartRx = 1'b1;
   logic        irq;

   int errors = 0;
   int checks = 0;

   logic [31:0] rd;
   logic        txTrace [0:79];
   logic        fullSeen [0:16];
   logic [7:0]  rxd [$];
   logic [9:0]  expFrame;
   bit          found;
   bit          seen;
   bit          busySeen;
   int          expCount;

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   uart_bus_slave #(.CLKS_PER_BIT(CPB), .TX_FIFO_DEPTH(16)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .bus_wdata_i (busWdata),
      .bus_addr_i  (busAddr),
      .bus_we_i    (busWe),
      .bus_hb_i    (busHb),
      .bus_ce_i    (busCe),
      .bus_req_i   (busReq),
      .bus_rdata_o (busRdata),
      .uart_tx_o   (uartTx),
      .uart_rx_i   (uartRx),
      .irq_o       (irq)
   );

   // Hard stop in case something never completes
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic idleBus();
      busCe = 1'b0;
      busReq = 1'b0;
      busWe = 1'b0;
      busAddr = '0;
      busWdata = '0;
      busHb = 2'b00;
   endtask

   // One bus cycle spanning a rising edge; read data is sampled before that edge
   task automatic applyStimulus(input logic we, input logic [1:0] off, input logic [1:0] hb,
                                input logic [31:0] wdata, output logic [31:0] rdata);
      @(negedge clk);
      busCe = 1'b1;
      busReq = 1'b1;
      busWe = we;
      busAddr = {28'h0, off, 2'b00};
      busHb = hb;
      busWdata = wdata;
      #1 rdata = busRdata;
      @(negedge clk);
      idleBus();
   endtask

   // Side-effect-free combinational read within the low phase of the clock
   task automatic peekReg(input logic [1:0] off, output logic [31:0] rdata);
      busCe = 1'b1;
      busReq = 1'b1;
      busWe = 1'b0;
      busAddr = {28'h0, off, 2'b00};
      busHb = 2'b10;
      #1 rdata = busRdata;
      #1 idleBus();
   endtask

   // Drives a frame onto the RX line; returns in the last cycle of the stop bit with the line high
   task automatic sendRx(input logic [7:0] data, input logic stopBit);
      logic [9:0] frame;
      frame = {stopBit, data, 1'b0};
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         uartRx = frame[k];
         repeat (CPB - 1) @(negedge clk);
      end
      uartRx = 1'b1;
   endtask

   task automatic decodeTxFrame(output logic [7:0] data, output bit ok, input int limit);
      bit got;
      got = 1'b0;
      ok = 1'b0;
      data = 8'h00;
      for (int i = 0; i < limit && !got; i++) begin
         @(negedge clk);
         if (uartTx === 1'b0) got = 1'b1;
      end
      if (got) begin
         repeat (3) @(negedge clk);
         for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            data[k] = uartTx;
         end
         repeat (CPB) @(negedge clk);
         ok = (uartTx === 1'b1);
      end
   endtask

   task automatic waitStatusBit(input int bitIdx, output bit hit);
      logic [31:0] s;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk);
         peekReg(2'd1, s);
         hit = s[bitIdx];
      end
   endtask

   initial begin
      $display("[TB] reset");
      idleBus();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_tx", uartTx, 1'b1);
      checkOutput("reset_irq", irq, 1'b0);
      peekReg(2'd1, rd);
      checkOutput("reset_status", rd, 32'h02);
      peekReg(2'd0, rd);
      checkOutput("txdata_read_zero", rd, 32'h0);

      $display("[TB] single TX byte 0xA5");
      applyStimulus(1'b1, 2'd0, 2'b10, 32'h0000_00A5, rd);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (uartTx === 1'b0) found = 1'b1;
      end
      checkOutput("tx_start_seen", found, 1'b1);
      if (found) begin
         txTrace[0] = uartTx;
         busySeen = 1'b0;
         for (int c = 1; c < 80; c++) begin
            @(negedge clk);
            txTrace[c] = uartTx;
            if (c == 40) begin
               peekReg(2'd1, rd);
               busySeen = rd[4];
            end
         end
         expFrame = {1'b1, 8'hA5, 1'b0};
         for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("tx_bit%0d_first", k), txTrace[8*k], expFrame[k]);
            checkOutput($sformatf("tx_bit%0d_last", k), txTrace[8*k+7], expFrame[k]);
         end
         checkOutput("tx_busy_mid", busySeen, 1'b1);
         @(negedge clk);
         checkOutput("tx_idle_after", uartTx, 1'b1);
         peekReg(2'd1, rd);
         checkOutput("status_after_tx", rd, 32'h02);
      end

      $display("[TB] FIFO fill with 17 writes");
      rxd.delete();
      fork
         begin : decoder
            logic [7:0] b;
            bit ok;
            for (int f = 0; f < 18; f++) begin
               decodeTxFrame(b, ok, 200);
               if (!ok) break;
               rxd.push_back(b);
            end
         end
         begin : writer
            applyStimulus(1'b1, 2'd0, 2'b00, 32'h11, rd);
            for (int i = 0; i < 17; i++) begin
               @(negedge clk);
               busCe = 1'b1;
               busReq = 1'b1;
               busWe = 1'b0;
               busAddr = 32'h4;
               busHb = 2'b10;
               #1 fullSeen[i] = busRdata[0];
               busWe = 1'b1;
               busAddr = 32'h0;
               busHb = 2'b00;
               busWdata = 32'h20 + i;
            end
            @(negedge clk);
            idleBus();
         end
      join
      for (int i = 0; i < 17; i++)
         checkOutput($sformatf("full_at_write%0d", i), fullSeen[i], (i == 16) ? 1'b1 : 1'b0);
      expCount = fullSeen[16] ? 17 : 18;
      checkOutput("tx_frame_count", 32'(rxd.size()), 32'(expCount));
      if (rxd.size() > 0) checkOutput("tx_frame0", rxd[0], 8'h11);
      for (int j = 1; j < 17 && j < rxd.size(); j++)
         checkOutput($sformatf("tx_frame%0d", j), rxd[j], 8'h20 + 8'(j - 1));

      $display("[TB] RX byte 0x3C");
      sendRx(8'h3C, 1'b1);
      waitStatusBit(2, seen);
      checkOutput("rx_valid_wait", seen, 1'b1);
      peekReg(2'd1, rd);
      checkOutput("status_rx_valid", rd, 32'h06);
      applyStimulus(1'b0, 2'd2, 2'b10, 32'h0, rd);
      checkOutput("rxdata_3c", rd, 32'h3C);
      peekReg(2'd1, rd);
      checkOutput("status_after_pop", rd, 32'h02);

      $display("[TB] RX overrun");
      sendRx(8'h5A, 1'b1);
      waitStatusBit(2, seen);
      checkOutput("rx_valid_wait2", seen, 1'b1);
      sendRx(8'hC3, 1'b1);
      waitStatusBit(3, seen);
      checkOutput("overrun_wait", seen, 1'b1);
      peekReg(2'd1, rd);
      checkOutput("status_overrun", rd, 32'h0E);
      applyStimulus(1'b0, 2'd2, 2'b10, 32'h0, rd);
      checkOutput("rxdata_second", rd, 32'hC3);
      applyStimulus(1'b1, 2'd3, 2'b10, 32'h4, rd);
      peekReg(2'd1, rd);
      checkOutput("status_overrun_cleared", rd, 32'h02);
      peekReg(2'd3, rd);
      checkOutput("ctrl_after_clear", rd, 32'h0);

      $display("[TB] reserved size write and framing error");
      applyStimulus(1'b1, 2'd3, 2'b11, 32'h3, rd);
      peekReg(2'd3, rd);
      checkOutput("ctrl_hb11_ignored", rd, 32'h0);
      sendRx(8'h77, 1'b0);
      repeat (4) @(negedge clk);
      peekReg(2'd1, rd);
      checkOutput("framing_discard", rd, 32'h02);

      $display("[TB] RX interrupt");
      applyStimulus(1'b1, 2'd3, 2'b00, 32'h1, rd);
      peekReg(2'd3, rd);
      checkOutput("ctrl_rx_en", rd, 32'h1);
      checkOutput("irq_before_rx", irq, 1'b0);
      sendRx(8'h96, 1'b1);
      waitStatusBit(2, seen);
      checkOutput("rx_valid_wait3", seen, 1'b1);
      checkOutput("irq_same_cycle_as_valid", irq, 1'b0);
      @(negedge clk);
      checkOutput("irq_rise", irq, 1'b1);
      applyStimulus(1'b0, 2'd2, 2'b10, 32'h0, rd);
      checkOutput("rxdata_96", rd, 32'h96);
      checkOutput("irq_after_pop_edge", irq, 1'b1);
      @(negedge clk);
      checkOutput("irq_fall", irq, 1'b0);

      $display("[TB] TX-empty interrupt");
      applyStimulus(1'b1, 2'd3, 2'b00, 32'h2, rd);
      checkOutput("irq_txe_lag", irq, 1'b0);
      @(negedge clk);
      checkOutput("irq_txe", irq, 1'b1);
      applyStimulus(1'b1, 2'd3, 2'b00, 32'h0, rd);
      @(negedge clk);
      checkOutput("irq_txe_off", irq, 1'b0);

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 2'd0, 2'b00, 32'h00, rd);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (uartTx === 1'b0) found = 1'b1;
      end
      checkOutput("tx_start_seen2", found, 1'b1);
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("tx_high_after_reset", uartTx, 1'b1);
      rst = 1'b0;
      peekReg(2'd1, rd);
      checkOutput("status_after_reset", rd, 32'h02);
      repeat (20) @(negedge clk);
      checkOutput("tx_stays_high", uartTx, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
